register_array_kv: RTL and testbench
====================================

# register_array_kv

Parametrised sorted register-array priority queue carrying a key plus an opaque payload per entry, selectable max-first or min-first ordering, stable ordering among equal keys, and occupancy/error status. It supports enqueue, dequeue and single-cycle replace, with one operation accepted per clock. It is the next-generation drop-in for the key-only register array, and it sits in front of schedulers that need the winning entry's tag along with its priority.

## Interface
- QUEUE_SIZE, 8, number of entry slots (≥2)
- KEY_WIDTH, 16, priority key width
- VAL_WIDTH, 8, payload width carried with each key
- MIN_FIRST, 0, 0: largest key at head; 1: smallest key at head
- CNT_WIDTH, $clog2(QUEUE_SIZE+1), width of occupancy count
- CLK  in  1  clock, all state on rising edge
- RSTn  in  1  asynchronous active-low reset
- i_wrt  in  1  write request (enqueue; with i_read = replace)
- i_read  in  1  read request (dequeue head; with i_wrt = replace)
- i_key  in  KEY_WIDTH  key of entry being written
- i_val  in  VAL_WIDTH  payload of entry being written
- o_key  out  KEY_WIDTH  head key, 0 when empty
- o_val  out  VAL_WIDTH  head payload, 0 when empty
- o_full  out  1  count == QUEUE_SIZE
- o_empty  out  1  count == 0
- o_count  out  CNT_WIDTH  current occupancy
- o_overflow  out  1  one-cycle pulse: enqueue dropped because full
- o_underflow  out  1  one-cycle pulse: dequeue ignored because empty
- o_drop_cnt  out  16  saturating dropped-request counter (only with REGISTER_ARRAY_KV_DROP_CNT_EN)

## Operation
- Each slot holds {valid, key, val}. Slot 0 is the head. Valid slots are contiguous from slot 0 and sorted by priority, where "beats" means key > (MIN_FIRST=0) or key < (MIN_FIRST=1).
- An invalid slot loses against every key.
- Ties are stable: a new entry lands after all existing entries with equal key, giving FIFO order among equals.
- Op decode from {i_wrt,i_read}: 00 NOP, 10 ENQ, 01 DEQ, 11 REPLACE.
- ENQ, not full: new entry is inserted at the first slot it beats; slots at and below that position shift down one; count+1.
- ENQ, full: state unchanged, o_overflow=1.
- DEQ, not empty: all slots shift up one, last slot is invalidated, count−1.
- DEQ, empty: state unchanged, o_underflow=1.
- REPLACE, not empty: head is removed and the new entry inserted into the remaining slots 1..N−1 in one cycle; count unchanged. This is legal when full.
- REPLACE, empty: behaves as ENQ and does not flag underflow.
- The new slot value is computed in parallel per slot from its own contents, its neighbours, and a per-slot "new beats me" compare vector. There is no iterative search.

## Timing
- All outputs are registered. Reset drives all valid=0, o_key/o_val=0, o_empty=1, o_full=0, o_count=0, pulses=0, o_drop_cnt=0.
- Requests are sampled on the rising CLK edge. The updated head, flags and count are visible immediately after that same edge (latency 1).
- Back-to-back operations every cycle are supported with no bubbles.
- o_overflow/o_underflow are high for exactly the cycle after the offending edge.
- RSTn assertion at any time clears state immediately and discards any in-flight request.

## Configuration
- REGISTER_ARRAY_KV_DROP_CNT_EN defined: the o_drop_cnt port exists. It increments on every o_overflow or o_underflow event, saturates at 16'hFFFF, and is cleared only by reset.
- Macro undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Package register_array_kv_pkg holds:
  - the op_t enum (OP_NOP, OP_ENQ, OP_DEQ, OP_REPLACE);
  - a parametrisable entry struct helper;
  - a beats() compare function taking MIN_FIRST.
- Sub-module register_array_kv_cell implements one slot. It takes its own entry, both neighbours, op and the compare bits, and selects keep / take-new / take-upper / take-lower. The top generates QUEUE_SIZE cells.

## Test plan
- Reset, then ENQ keys 5,9,1 with vals A,B,C (MIN_FIRST=0) → head 9/B, count 3; DEQ → head 5/A, count 2.
- ENQ key 7 val 1, then key 7 val 2, then DEQ → first dequeue yields 7/1, next head 7/2 (stability).
- Fill 8 entries, then ENQ → o_overflow pulse, count stays 8, head unchanged. REPLACE key 1023 → head 1023, count 8, no overflow.
- From empty, DEQ → o_underflow pulse, o_key=0, o_empty=1. REPLACE key 4 → count 1, head 4.
- MIN_FIRST=1: ENQ 30,10,20 → head 10; REPLACE 15 → head 15, then 20, 30 on successive DEQ.
- Random mix of 500 ops checked every cycle against a stable-sorted model. With REGISTER_ARRAY_KV_DROP_CNT_EN, o_drop_cnt equals the model's overflow+underflow total.

Source files
------------

// File: rtl/register_array_kv_pkg.sv
// Shared types and helpers for the keyed register-array priority queue.
// Optional drop counter: REGISTER_ARRAY_KV_DROP_CNT_EN.
package register_array_kv_pkg;

  typedef enum logic [1:0] {
    OP_NOP     = 2'b00,
    OP_DEQ     = 2'b01,
    OP_ENQ     = 2'b10,
    OP_REPLACE = 2'b11
  } op_t;

  // Packed entry layout is {valid, key, val}, MSB first.
  function automatic int entry_bits(input int kw, input int vw);
    return 1 + kw + vw;
  endfunction

  function automatic logic beats(
    input logic [63:0] a,
    input logic [63:0] b,
    input logic        min_first
  );
    return min_first ? (a < b) : (a > b);
  endfunction

endpackage

// File: rtl/register_array_kv_cell.sv
// One slot of the sorted array: keeps, takes the new entry, or shifts.
// Optional drop counter: REGISTER_ARRAY_KV_DROP_CNT_EN (top only).
module register_array_kv_cell
  import register_array_kv_pkg::*;
#(
  parameter int EW   = 25,
  parameter bit HEAD = 1'b0
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  op_t           op,
  input  logic          nb_self,
  input  logic          nb_upper,
  input  logic          nb_lower,
  input  logic [EW-1:0] upper,
  input  logic [EW-1:0] lower,
  input  logic [EW-1:0] new_ent,
  output logic [EW-1:0] q
);

  logic          take_new;
  logic          take_up;
  logic          take_lo;
  logic [EW-1:0] nxt;

  // Replace: the list below the head shifts up by one, then the new
  // entry is inserted; a slot past the insert point ends up unchanged.
  always_comb begin
    take_new = 1'b0;
    take_up  = 1'b0;
    take_lo  = 1'b0;
    unique case (op)
      OP_ENQ: begin
        take_new = nb_self & ~nb_upper;
        take_up  = nb_self & nb_upper;
      end
      OP_DEQ: take_lo = 1'b1;
      OP_REPLACE: begin
        take_lo  = ~nb_lower;
        take_new = nb_lower & (HEAD | ~nb_self);
      end
      default: ;
    endcase
  end

  always_comb begin
    nxt = q;
    unique case (1'b1)
      take_new: nxt = new_ent;
      take_up:  nxt = upper;
      take_lo:  nxt = lower;
      default:  nxt = q;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) q <= '0;
    else       q <= nxt;
  end

endmodule

// File: rtl/register_array_kv.sv
// Sorted register-array priority queue with key plus payload per entry.
// Optional drop counter: REGISTER_ARRAY_KV_DROP_CNT_EN.
module register_array_kv
  import register_array_kv_pkg::*;
#(
  parameter int QUEUE_SIZE = 8,
  parameter int KEY_WIDTH  = 16,
  parameter int VAL_WIDTH  = 8,
  parameter bit MIN_FIRST  = 1'b0,
  parameter int CNT_WIDTH  = $clog2(QUEUE_SIZE + 1)
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic                 i_wrt,
  input  logic                 i_read,
  input  logic [KEY_WIDTH-1:0] i_key,
  input  logic [VAL_WIDTH-1:0] i_val,
  output logic [KEY_WIDTH-1:0] o_key,
  output logic [VAL_WIDTH-1:0] o_val,
  output logic                 o_full,
  output logic                 o_empty,
  output logic [CNT_WIDTH-1:0] o_count,
  output logic                 o_overflow,
  output logic                 o_underflow
`ifdef REGISTER_ARRAY_KV_DROP_CNT_EN
  ,
  output logic [15:0]          o_drop_cnt
`endif
);

  localparam int EW = entry_bits(KEY_WIDTH, VAL_WIDTH);
  localparam logic [CNT_WIDTH-1:0] FULL_CNT =
    CNT_WIDTH'(QUEUE_SIZE);

  logic [EW-1:0]         ent [QUEUE_SIZE];
  logic [QUEUE_SIZE-1:0] nb;
  logic [EW-1:0]         new_ent;
  op_t                   op_raw;
  op_t                   op;
  logic [CNT_WIDTH-1:0]  cnt_nxt;
  logic                  ovf_nxt;
  logic                  unf_nxt;

  assign new_ent = {1'b1, i_key, i_val};
  assign op_raw  = op_t'({i_wrt, i_read});

  // Illegal requests collapse to NOP; replace on empty is a plain enqueue.
  always_comb begin
    op      = op_raw;
    cnt_nxt = o_count;
    ovf_nxt = 1'b0;
    unf_nxt = 1'b0;
    unique case (op_raw)
      OP_ENQ: begin
        if (o_full) begin
          op      = OP_NOP;
          ovf_nxt = 1'b1;
        end else begin
          cnt_nxt = o_count + 1'b1;
        end
      end
      OP_DEQ: begin
        if (o_empty) begin
          op      = OP_NOP;
          unf_nxt = 1'b1;
        end else begin
          cnt_nxt = o_count - 1'b1;
        end
      end
      OP_REPLACE: begin
        if (o_empty) begin
          op      = OP_ENQ;
          cnt_nxt = o_count + 1'b1;
        end
      end
      default: ;
    endcase
  end

  for (genvar i = 0; i < QUEUE_SIZE; i++) begin : g_slot
    logic [EW-1:0] up_e;
    logic [EW-1:0] lo_e;
    logic          nb_up;
    logic          nb_lo;

    // Strict compare keeps equal keys in arrival order.
    assign nb[i] = ~ent[i][EW-1] |
      beats(64'(i_key), 64'(ent[i][EW-2 -: KEY_WIDTH]), MIN_FIRST);

    if (i == 0) begin : g_top
      assign up_e  = '0;
      assign nb_up = 1'b0;
    end else begin : g_mid_up
      assign up_e  = ent[i-1];
      assign nb_up = nb[i-1];
    end

    if (i == QUEUE_SIZE - 1) begin : g_bot
      assign lo_e  = '0;
      assign nb_lo = 1'b1;
    end else begin : g_mid_lo
      assign lo_e  = ent[i+1];
      assign nb_lo = nb[i+1];
    end

    register_array_kv_cell #(
      .EW   (EW),
      .HEAD (i == 0)
    ) u_cell (
      .CLK      (CLK),
      .RSTn     (RSTn),
      .op       (op),
      .nb_self  (nb[i]),
      .nb_upper (nb_up),
      .nb_lower (nb_lo),
      .upper    (up_e),
      .lower    (lo_e),
      .new_ent  (new_ent),
      .q        (ent[i])
    );
  end

  // Invalid slots always hold zero, so the head maps straight out.
  assign o_key = ent[0][EW-2 -: KEY_WIDTH];
  assign o_val = ent[0][VAL_WIDTH-1:0];

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      o_count     <= '0;
      o_full      <= 1'b0;
      o_empty     <= 1'b1;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      o_count     <= cnt_nxt;
      o_full      <= (cnt_nxt == FULL_CNT);
      o_empty     <= (cnt_nxt == '0);
      o_overflow  <= ovf_nxt;
      o_underflow <= unf_nxt;
    end
  end

`ifdef REGISTER_ARRAY_KV_DROP_CNT_EN
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      o_drop_cnt <= '0;
    end else if ((ovf_nxt | unf_nxt) && (o_drop_cnt != 16'hFFFF)) begin
      o_drop_cnt <= o_drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_register_array_kv.sv
// Bench for register_array_kv: max-first and min-first instances, scoreboard.
// Build with REGISTER_ARRAY_KV_DROP_CNT_EN to cover the drop counter.
module tb_register_array_kv;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        i_wrt;
  logic        i_read;
  logic [15:0] i_key;
  logic [7:0]  i_val;
  logic [15:0] key0, key1;
  logic [7:0]  val0, val1;
  logic        full0, full1, empty0, empty1;
  logic [3:0]  cnt0, cnt1;
  logic        ovf0, ovf1, unf0, unf1;
`ifdef REGISTER_ARRAY_KV_DROP_CNT_EN
  logic [15:0] drop0, drop1;
`endif

  always #5 CLK = ~CLK;

  register_array_kv u_max (
    .CLK(CLK), .RSTn(RSTn), .i_wrt(i_wrt), .i_read(i_read),
    .i_key(i_key), .i_val(i_val), .o_key(key0), .o_val(val0),
    .o_full(full0), .o_empty(empty0), .o_count(cnt0),
    .o_overflow(ovf0), .o_underflow(unf0)
`ifdef REGISTER_ARRAY_KV_DROP_CNT_EN
    , .o_drop_cnt(drop0)
`endif
  );

  register_array_kv #(.MIN_FIRST(1'b1)) u_min (
    .CLK(CLK), .RSTn(RSTn), .i_wrt(i_wrt), .i_read(i_read),
    .i_key(i_key), .i_val(i_val), .o_key(key1), .o_val(val1),
    .o_full(full1), .o_empty(empty1), .o_count(cnt1),
    .o_overflow(ovf1), .o_underflow(unf1)
`ifdef REGISTER_ARRAY_KV_DROP_CNT_EN
    , .o_drop_cnt(drop1)
`endif
  );

  typedef struct packed {
    logic [15:0] k;
    logic [7:0]  v;
  } kv_t;

  typedef struct packed {
    logic [15:0] k;
    logic [7:0]  v;
    logic [3:0]  c;
    logic        f;
    logic        e;
    logic        o;
    logic        u;
  } obs_t;

  typedef struct packed {
    obs_t a;
    obs_t b;
  } pair_t;

  kv_t   mk [2][8];
  int    mc [2];
  int    mdrop [2];
  pair_t exp_q [$];
  pair_t act_q [$];
  int    checks = 0;
  int    errors = 0;

  function automatic logic mbeats(input logic [15:0] a, input logic [15:0] b,
                                  input int d);
    return (d != 0) ? (a < b) : (a > b);
  endfunction

  function automatic void mins(input int d, input kv_t e);
    int pos;
    pos = mc[d];
    for (int i = 0; i < mc[d]; i++) begin
      if (mbeats(e.k, mk[d][i].k, d)) begin
        pos = i;
        break;
      end
    end
    for (int i = mc[d]; i > pos; i--) mk[d][i] = mk[d][i-1];
    mk[d][pos] = e;
    mc[d]++;
  endfunction

  function automatic void mdel(input int d);
    for (int i = 0; i < mc[d] - 1; i++) mk[d][i] = mk[d][i+1];
    mc[d]--;
  endfunction

  function automatic obs_t mstep(input int d, input logic w, input logic r,
                                 input kv_t e);
    obs_t o;
    o = '0;
    if (w && !r) begin
      if (mc[d] == 8) o.o = 1'b1;
      else mins(d, e);
    end else if (!w && r) begin
      if (mc[d] == 0) o.u = 1'b1;
      else mdel(d);
    end else if (w && r) begin
      if (mc[d] != 0) mdel(d);
      mins(d, e);
    end
    mdrop[d] += int'(o.o) + int'(o.u);
    o.c = 4'(mc[d]);
    o.f = (mc[d] == 8);
    o.e = (mc[d] == 0);
    if (mc[d] > 0) begin
      o.k = mk[d][0].k;
      o.v = mk[d][0].v;
    end
    return o;
  endfunction

  function automatic obs_t got(input int d);
    if (d != 0) return {key1, val1, cnt1, full1, empty1, ovf1, unf1};
    return {key0, val0, cnt0, full0, empty0, ovf0, unf0};
  endfunction

  task automatic drive(input logic w, input logic r,
                       input logic [15:0] k, input logic [7:0] v);
    pair_t e;
    i_wrt  = w;
    i_read = r;
    i_key  = k;
    i_val  = v;
    e.a = mstep(0, w, r, {k, v});
    e.b = mstep(1, w, r, {k, v});
    exp_q.push_back(e);
    @(posedge CLK);
    #1;
    act_q.push_back({got(0), got(1)});
  endtask

  task automatic do_reset();
    #2;
    RSTn   = 1'b0;
    i_wrt  = 1'b0;
    i_read = 1'b0;
    i_key  = '0;
    i_val  = '0;
    mc     = '{0, 0};
    mdrop  = '{0, 0};
    exp_q.delete();
    act_q.delete();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RSTn = 1'b1;
  endtask

  task automatic test_reset();
    pair_t e, a;
    do_reset();
    drive(1'b1, 1'b0, 16'd3, 8'h11);
    drive(1'b1, 1'b0, 16'd4, 8'h22);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL sb_reset got=%h exp=%h", a, e);
      end
    end
    #2 RSTn = 1'b0;
    #1;
    checks++;
    if ({key0, val0, cnt0, full0, empty0, ovf0, unf0} !==
        {16'd0, 8'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset key=%0d val=%0d cnt=%0d e=%b exp 0/0/0/1",
               key0, val0, cnt0, empty0);
    end
    checks++;
    if ({key1, cnt1, empty1} !== {16'd0, 4'd0, 1'b1}) begin
      errors++;
      $display("FAIL async_reset_min key=%0d cnt=%0d e=%b", key1, cnt1, empty1);
    end
`ifdef REGISTER_ARRAY_KV_DROP_CNT_EN
    checks++;
    if (drop0 !== 16'd0) begin
      errors++;
      $display("FAIL reset_drop got=%0d exp=0", drop0);
    end
`endif
    do_reset();
  endtask

  task automatic test_basic();
    pair_t e, a;
    drive(1'b1, 1'b0, 16'd5, 8'h0A);
    drive(1'b1, 1'b0, 16'd9, 8'h0B);
    drive(1'b1, 1'b0, 16'd1, 8'h0C);
    checks++;
    if ({key0, val0, cnt0} !== {16'd9, 8'h0B, 4'd3}) begin
      errors++;
      $display("FAIL basic_enq got=%0d/%h/%0d exp=9/0b/3", key0, val0, cnt0);
    end
    drive(1'b0, 1'b1, 16'd0, 8'h00);
    checks++;
    if ({key0, val0, cnt0} !== {16'd5, 8'h0A, 4'd2}) begin
      errors++;
      $display("FAIL basic_deq got=%0d/%h/%0d exp=5/0a/2", key0, val0, cnt0);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL sb_basic got=%h exp=%h", a, e);
      end
    end
  endtask

  task automatic test_stability();
    pair_t e, a;
    drive(1'b1, 1'b0, 16'd7, 8'h01);
    drive(1'b1, 1'b0, 16'd7, 8'h02);
    checks++;
    if ({key0, val0} !== {16'd7, 8'h01}) begin
      errors++;
      $display("FAIL stable_first got=%0d/%h exp=7/01", key0, val0);
    end
    drive(1'b0, 1'b1, 16'd0, 8'h00);
    checks++;
    if ({key0, val0} !== {16'd7, 8'h02}) begin
      errors++;
      $display("FAIL stable_second got=%0d/%h exp=7/02", key0, val0);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL sb_stable got=%h exp=%h", a, e);
      end
    end
  endtask

  task automatic test_overflow();
    pair_t e, a;
    do_reset();
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 16'(100 + 10 * i), 8'(i));
    checks++;
    if ({key0, cnt0, full0} !== {16'd170, 4'd8, 1'b1}) begin
      errors++;
      $display("FAIL fill got=%0d/%0d/%b exp=170/8/1", key0, cnt0, full0);
    end
    drive(1'b1, 1'b0, 16'd500, 8'hEE);
    checks++;
    if ({ovf0, cnt0, key0} !== {1'b1, 4'd8, 16'd170}) begin
      errors++;
      $display("FAIL overflow got=%b/%0d/%0d exp=1/8/170", ovf0, cnt0, key0);
    end
    drive(1'b0, 1'b0, 16'd0, 8'h00);
    checks++;
    if (ovf0 !== 1'b0) begin
      errors++;
      $display("FAIL overflow_pulse got=%b exp=0", ovf0);
    end
    drive(1'b1, 1'b1, 16'd1023, 8'h55);
    checks++;
    if ({key0, val0, cnt0, ovf0} !== {16'd1023, 8'h55, 4'd8, 1'b0}) begin
      errors++;
      $display("FAIL replace_full got=%0d/%h/%0d/%b exp=1023/55/8/0",
               key0, val0, cnt0, ovf0);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL sb_overflow got=%h exp=%h", a, e);
      end
    end
  endtask

  task automatic test_underflow();
    pair_t e, a;
    do_reset();
    drive(1'b0, 1'b1, 16'd0, 8'h00);
    checks++;
    if ({unf0, key0, empty0} !== {1'b1, 16'd0, 1'b1}) begin
      errors++;
      $display("FAIL underflow got=%b/%0d/%b exp=1/0/1", unf0, key0, empty0);
    end
    drive(1'b1, 1'b1, 16'd4, 8'h44);
    checks++;
    if ({cnt0, key0, unf0} !== {4'd1, 16'd4, 1'b0}) begin
      errors++;
      $display("FAIL replace_empty got=%0d/%0d/%b exp=1/4/0", cnt0, key0, unf0);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL sb_underflow got=%h exp=%h", a, e);
      end
    end
  endtask

  task automatic test_min_first();
    pair_t e, a;
    do_reset();
    drive(1'b1, 1'b0, 16'd30, 8'h03);
    drive(1'b1, 1'b0, 16'd10, 8'h01);
    drive(1'b1, 1'b0, 16'd20, 8'h02);
    checks++;
    if (key1 !== 16'd10) begin
      errors++;
      $display("FAIL min_head got=%0d exp=10", key1);
    end
    drive(1'b1, 1'b1, 16'd15, 8'h05);
    checks++;
    if ({key1, cnt1} !== {16'd15, 4'd3}) begin
      errors++;
      $display("FAIL min_replace got=%0d/%0d exp=15/3", key1, cnt1);
    end
    drive(1'b0, 1'b1, 16'd0, 8'h00);
    checks++;
    if (key1 !== 16'd20) begin
      errors++;
      $display("FAIL min_deq1 got=%0d exp=20", key1);
    end
    drive(1'b0, 1'b1, 16'd0, 8'h00);
    checks++;
    if (key1 !== 16'd30) begin
      errors++;
      $display("FAIL min_deq2 got=%0d exp=30", key1);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL sb_min got=%h exp=%h", a, e);
      end
    end
  endtask

  task automatic test_random();
    pair_t e, a;
    int    sel;
    logic  w, r;
    do_reset();
    for (int i = 0; i < 500; i++) begin
      sel = $urandom_range(0, 9);
      if (((i / 60) % 2) == 0) begin
        w = (sel < 6) || (sel == 8);
        r = ((sel >= 6) && (sel < 8)) || (sel == 8);
      end else begin
        w = (sel < 2) || (sel == 8);
        r = ((sel >= 2) && (sel < 8)) || (sel == 8);
      end
      drive(w, r, 16'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL sb_random got=%h exp=%h", a, e);
      end
    end
`ifdef REGISTER_ARRAY_KV_DROP_CNT_EN
    checks++;
    if ({drop0, drop1} !== {16'(mdrop[0]), 16'(mdrop[1])}) begin
      errors++;
      $display("FAIL drop_cnt got=%0d/%0d exp=%0d/%0d",
               drop0, drop1, mdrop[0], mdrop[1]);
    end
`endif
  endtask

  initial begin
    RSTn   = 1'b0;
    i_wrt  = 1'b0;
    i_read = 1'b0;
    i_key  = '0;
    i_val  = '0;
    test_reset();
    test_basic();
    test_stability();
    test_overflow();
    test_underflow();
    test_min_first();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
